// File: rtl/mul_share_arbiter.sv
// rtl/mul_share_arbiter.sv - round-robin arbiter sharing one serial multiplier between two requesters
module mul_share_arbiter #(
    parameter int N     = 32,
    parameter int CNT_W = $clog2(2*N)+1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0,
    input  logic [N-1:0]   a0,
    input  logic [N-1:0]   b0,
    output logic           done0,
    input  logic           req1,
    input  logic [N-1:0]   a1,
    input  logic [N-1:0]   b1,
    output logic           done1,
    output logic [2*N-1:0] result,
    output logic           busy,
    output logic           gnt_id,
    output logic           mul_start,
    output logic [N-1:0]   mul_multiplier,
    output logic [N-1:0]   mul_multiplicand,
    input  logic           mul_out
);

    typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(2*N-1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             last_srv;
    logic             pick;

    // On a tie the requester not served last time wins; otherwise the sole requester.
    assign pick = (req0 && req1) ? ~last_srv : req1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            done0            <= 1'b0;
            done1            <= 1'b0;
            busy             <= 1'b0;
            mul_start        <= 1'b0;
            gnt_id           <= 1'b0;
            result           <= '0;
            mul_multiplier   <= '0;
            mul_multiplicand <= '0;
            cnt              <= '0;
            last_srv         <= 1'b1;
        end else begin
            done0     <= 1'b0;
            done1     <= 1'b0;
            mul_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        gnt_id           <= pick;
                        mul_multiplier   <= pick ? a1 : a0;
                        mul_multiplicand <= pick ? b1 : b0;
                        mul_start        <= 1'b1;
                        busy             <= 1'b1;
                        state            <= START;
                    end
                end
                START: begin
                    cnt    <= '0;
                    result <= '0;
                    state  <= RUN;
                end
                RUN: begin
                    // LSB arrives first, so shifting right leaves it in result[0].
                    result <= {mul_out, result[2*N-1:1]};
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        done0 <= ~gnt_id;
                        done1 <= gnt_id;
                        state <= DONE;
                    end
                end
                DONE: begin
                    last_srv <= gnt_id;
                    gnt_id   <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
